// File: rtl/jt1943_objdma_ctrl.sv
// rtl/jt1943_objdma_ctrl.sv - sprite-table DMA sequencer, CPU object RAM to scan RAM once per frame
// Optional pause gating of the transfer start: JT1943_OBJDMA_PAUSE_EN
module jt1943_objdma_ctrl #(
    parameter int            AW     = 9,
    parameter logic [AW-1:0] OBJMAX = 9'h1FF
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen6,
    input  logic          LVBL,
    input  logic          OKOUT,
    input  logic          pause,
    output logic          bus_req,
    input  logic          bus_ack,
    output logic          blen,
    output logic [AW-1:0] dma_addr,
    input  logic [7:0]    DB,
    output logic          ram_we,
    output logic [7:0]    ram_din,
    output logic [AW-1:0] ram_waddr,
    output logic          dma_done,
    output logic          dma_abort
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] COPY  = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    logic [1:0] state;
    logic       lvbl_q;
    logic       ok_flag;
    logic       we_pend;
    logic       start_ok;
    logic       vb_edge;
    logic       vb_rise;
    logic       fetch;
    logic       start;

`ifdef JT1943_OBJDMA_PAUSE_EN
    assign start_ok = ~pause;
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign start_ok     = 1'b1;
`endif

    assign vb_edge = lvbl_q & ~LVBL;
    assign vb_rise = ~lvbl_q & LVBL;
    assign start   = cen6 && state == IDLE && vb_edge && ok_flag && start_ok;

    // A blanking end cuts the fetch in the same slot; the already fetched byte still lands
    assign blen   = (state == COPY) && bus_ack && !vb_rise;
    assign fetch  = cen6 && blen;
    assign ram_we = we_pend & cen6;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lvbl_q    <= 1'b0;
            ok_flag   <= 1'b0;
            we_pend   <= 1'b0;
            bus_req   <= 1'b0;
            dma_addr  <= '0;
            ram_din   <= 8'd0;
            ram_waddr <= '0;
            dma_done  <= 1'b0;
            dma_abort <= 1'b0;
        end else begin
            // A new OKOUT beats the clear so a table posted during start is kept
            if (OKOUT)
                ok_flag <= 1'b1;
            else if (start)
                ok_flag <= 1'b0;

            if (cen6) begin
                lvbl_q    <= LVBL;
                dma_done  <= 1'b0;
                dma_abort <= 1'b0;
                we_pend   <= fetch;
                if (fetch) begin
                    ram_din   <= DB;
                    ram_waddr <= dma_addr;
                end

                case (state)
                    IDLE: begin
                        if (vb_edge && ok_flag && start_ok) begin
                            state   <= REQ;
                            bus_req <= 1'b1;
                        end
                    end
                    REQ: begin
                        if (vb_rise) begin
                            bus_req   <= 1'b0;
                            dma_abort <= 1'b1;
                            state     <= IDLE;
                        end else if (bus_ack) begin
                            state    <= COPY;
                            dma_addr <= '0;
                        end
                    end
                    COPY: begin
                        if (vb_rise) begin
                            bus_req   <= 1'b0;
                            dma_abort <= 1'b1;
                            state     <= IDLE;
                        end else if (bus_ack) begin
                            if (dma_addr == OBJMAX)
                                state <= FLUSH;
                            else
                                dma_addr <= dma_addr + AW'(1);
                        end
                    end
                    default: begin
                        bus_req  <= 1'b0;
                        dma_done <= 1'b1;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jt1943_objdma_ctrl.sv
// tb/tb_jt1943_objdma_ctrl.sv - randomized self-checking bench for jt1943_objdma_ctrl
`timescale 1ns/1ps
module tb_jt1943_objdma_ctrl;

    localparam int N      = 512;
    localparam int OBJMAX = 511;

    logic       clk = 1'b0, rst_n = 1'b0, cen6 = 1'b0, LVBL = 1'b1;
    logic       OKOUT = 1'b0, pause = 1'b0, bus_ack = 1'b0;
    logic       bus_req, blen, ram_we, dma_done, dma_abort;
    logic [8:0] dma_addr, ram_waddr;
    logic [7:0] DB, ram_din;

    logic [7:0] cpu_ram  [N];
    logic [7:0] scan     [N];
    logic [7:0] exp_scan [N];

    int pass_cnt = 0, check_cnt = 0;
    int cdiv = 0;
    int slot = 0, last_wr_slot = 0, done_slot = 0, abort_slot = 0;
    int done_n = 0, abort_n = 0;
    logic done_busreq = 1'b0, abort_busreq = 1'b0;
    int wq[$];

    int b_done, b_abort, b_wq, ack_slot;
    int obs_addr[$];
    logic obs_blen[$];
    logic [2:0] rst_obs;

    jt1943_objdma_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cen6(cen6), .LVBL(LVBL), .OKOUT(OKOUT),
        .pause(pause), .bus_req(bus_req), .bus_ack(bus_ack), .blen(blen),
        .dma_addr(dma_addr), .DB(DB), .ram_we(ram_we), .ram_din(ram_din),
        .ram_waddr(ram_waddr), .dma_done(dma_done), .dma_abort(dma_abort)
    );

    assign DB = cpu_ram[dma_addr];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        cdiv = (cdiv + 1) % 2;
        cen6 = (cdiv == 0);
    end

    // Scan RAM model and event log, one sample per cen6 slot
    always @(negedge clk) begin
        if (cen6) begin
            slot++;
            if (ram_we) begin
                scan[ram_waddr] = ram_din;
                wq.push_back(int'(ram_waddr));
                last_wr_slot = slot;
            end
            if (dma_done) begin
                done_n++;
                done_slot   = slot;
                done_busreq = bus_req;
            end
            if (dma_abort) begin
                abort_n++;
                abort_slot   = slot;
                abort_busreq = bus_req;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic next_slot();
        do @(negedge clk); while (!cen6);
        #1;
    endtask

    task automatic snap();
        b_done  = done_n;
        b_abort = abort_n;
        b_wq    = wq.size();
        obs_addr.delete();
        obs_blen.delete();
    endtask

    task automatic fill_ram(input int keep_below, input int use_old);
        for (int a = 0; a < N; a++) begin
            cpu_ram[a] = 8'($urandom);
            exp_scan[a] = (use_old != 0 && a >= keep_below) ? scan[a] : cpu_ram[a];
        end
    endtask

    function automatic int scan_errs();
        int e = 0;
        for (int a = 0; a < N; a++)
            if (scan[a] !== exp_scan[a]) e++;
        return e;
    endfunction

    function automatic int order_errs(input int cnt);
        int e = 0;
        for (int i = 0; i < cnt; i++)
            if (wq[b_wq + i] != i) e++;
        return e;
    endfunction

    task automatic start_frame(input bit ok, input bit ok_at_edge);
        if (ok) begin
            next_slot(); OKOUT = 1'b1;
            next_slot(); OKOUT = 1'b0;
        end
        LVBL = 1'b1;
        next_slot();
        next_slot();
        LVBL = 1'b0;
        if (ok_at_edge) OKOUT = 1'b1;
    endtask

    task automatic end_frame();
        bus_ack = 1'b0;
        LVBL    = 1'b1;
        next_slot();
        next_slot();
    endtask

    task automatic run_copy(input int drop_at, input int abort_at, input int rst_at,
                            output bit timeout);
        int k = 0;
        int drop_left = 0;
        timeout  = 1'b0;
        bus_ack  = 1'b1;
        ack_slot = slot;
        while (done_n == b_done && abort_n == b_abort) begin
            next_slot();
            k++;
            if (k > 3000) begin timeout = 1'b1; break; end
            if (drop_left > 0) begin
                drop_left--;
                if (drop_left == 0) bus_ack = 1'b1;
                else begin
                    obs_blen.push_back(blen);
                    obs_addr.push_back(int'(dma_addr));
                end
            end else if (blen && int'(dma_addr) == drop_at) begin
                bus_ack   = 1'b0;
                drop_left = 3;
                #1;
                obs_blen.push_back(blen);
                obs_addr.push_back(int'(dma_addr));
            end else if (blen && int'(dma_addr) == abort_at) begin
                LVBL = 1'b1;
            end else if (blen && int'(dma_addr) == rst_at) begin
                rst_n = 1'b0;
                #1;
                rst_obs = {bus_req, blen, ram_we};
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check_cnt++;
        if ({bus_req, blen, ram_we, dma_done, dma_abort} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {bus_req, blen, ram_we, dma_done, dma_abort});
        else pass_cnt++;
        check_cnt++;
        if ({dma_addr, ram_waddr, ram_din} !== 26'd0)
            $display("FAIL reset_data: got %h want 0", {dma_addr, ram_waddr, ram_din});
        else pass_cnt++;
        #1 rst_n = 1'b1;
        next_slot();
        next_slot();
        check_cnt++;
        if (bus_req !== 1'b0) $display("FAIL reset_idle_req: got %b want 0", bus_req);
        else pass_cnt++;
    endtask

    task automatic test_full();
        bit to;
        fill_ram(0, 0);
        snap();
        start_frame(1, 0);
        check_cnt++;
        if (bus_req !== 1'b0) $display("FAIL full_req_pre: got %b want 0", bus_req);
        else pass_cnt++;
        next_slot();
        check_cnt++;
        if (bus_req !== 1'b1) $display("FAIL full_req_edge: got %b want 1", bus_req);
        else pass_cnt++;
        next_slot();
        run_copy(-1, -1, -1, to);
        check_cnt++;
        if (to) $display("FAIL full_timeout: got timeout want dma_done");
        else pass_cnt++;
        check_cnt++;
        if (wq.size() - b_wq != N) $display("FAIL full_nwrites: got %0d want %0d", wq.size() - b_wq, N);
        else pass_cnt++;
        check_cnt++;
        if (order_errs(N) != 0) $display("FAIL full_order: got %0d bad addrs want 0", order_errs(N));
        else pass_cnt++;
        check_cnt++;
        if (scan_errs() != 0) $display("FAIL full_data: got %0d bad bytes want 0", scan_errs());
        else pass_cnt++;
        check_cnt++;
        if (done_slot - last_wr_slot != 1)
            $display("FAIL full_done_lat: got %0d want 1", done_slot - last_wr_slot);
        else pass_cnt++;
        check_cnt++;
        if (done_busreq !== 1'b0) $display("FAIL full_done_req: got %b want 0", done_busreq);
        else pass_cnt++;
        check_cnt++;
        if (done_slot - ack_slot != OBJMAX + 3)
            $display("FAIL full_total: got %0d want %0d", done_slot - ack_slot, OBJMAX + 3);
        else pass_cnt++;
        check_cnt++;
        if (abort_n != b_abort) $display("FAIL full_no_abort: got %0d want 0", abort_n - b_abort);
        else pass_cnt++;
        end_frame();
    endtask

    task automatic test_no_okout();
        int seen = 0;
        snap();
        start_frame(0, 0);
        for (int i = 0; i < 30; i++) begin
            next_slot();
            if (bus_req) seen++;
        end
        check_cnt++;
        if (seen != 0) $display("FAIL nook_req: got %0d slots with bus_req want 0", seen);
        else pass_cnt++;
        end_frame();
    endtask

    task automatic test_ack_drop();
        bit to;
        int bad = 0;
        fill_ram(0, 0);
        snap();
        start_frame(1, 0);
        next_slot();
        next_slot();
        run_copy(9'h080, -1, -1, to);
        for (int i = 0; i < obs_addr.size(); i++)
            if (obs_addr[i] != 9'h080 || obs_blen[i] !== 1'b0) bad++;
        check_cnt++;
        if (obs_addr.size() != 3 || bad != 0)
            $display("FAIL drop_hold: got %0d samples %0d bad want 3 samples 0 bad", obs_addr.size(), bad);
        else pass_cnt++;
        check_cnt++;
        if (to || wq.size() - b_wq != N)
            $display("FAIL drop_nwrites: got %0d want %0d", wq.size() - b_wq, N);
        else pass_cnt++;
        check_cnt++;
        if (order_errs(N) != 0 || scan_errs() != 0)
            $display("FAIL drop_data: got %0d/%0d bad want 0/0", order_errs(N), scan_errs());
        else pass_cnt++;
        end_frame();
    endtask

    task automatic test_abort();
        bit to;
        fill_ram(9'h100, 1);
        snap();
        start_frame(1, 0);
        next_slot();
        next_slot();
        run_copy(-1, 9'h100, -1, to);
        check_cnt++;
        if (to || abort_n - b_abort != 1 || done_n != b_done)
            $display("FAIL abort_pulse: got abort %0d done %0d want 1 0", abort_n - b_abort, done_n - b_done);
        else pass_cnt++;
        check_cnt++;
        if (wq.size() - b_wq != 9'h100 || wq[wq.size() - 1] != 9'h0FF)
            $display("FAIL abort_writes: got %0d last %0h want 256 last ff", wq.size() - b_wq, wq[wq.size() - 1]);
        else pass_cnt++;
        check_cnt++;
        if (abort_slot - last_wr_slot != 1 || abort_busreq !== 1'b0)
            $display("FAIL abort_timing: got lat %0d req %b want 1 0", abort_slot - last_wr_slot, abort_busreq);
        else pass_cnt++;
        check_cnt++;
        if (scan_errs() != 0) $display("FAIL abort_data: got %0d bad bytes want 0", scan_errs());
        else pass_cnt++;
        end_frame();
    endtask

    task automatic test_reset_mid();
        bit to;
        fill_ram(0, 0);
        snap();
        start_frame(1, 0);
        next_slot();
        next_slot();
        run_copy(-1, -1, 9'h050, to);
        check_cnt++;
        if (rst_obs !== 3'b000) $display("FAIL rstmid_async: got %b want 000", rst_obs);
        else pass_cnt++;
        next_slot();
        rst_n = 1'b1;
        end_frame();
        fill_ram(0, 0);
        snap();
        start_frame(1, 0);
        next_slot();
        next_slot();
        run_copy(-1, -1, -1, to);
        check_cnt++;
        if (to || wq.size() - b_wq != N || wq[b_wq] != 0)
            $display("FAIL rstmid_restart: got %0d writes first %0d want %0d first 0", wq.size() - b_wq, wq[b_wq], N);
        else pass_cnt++;
        check_cnt++;
        if (scan_errs() != 0) $display("FAIL rstmid_data: got %0d bad bytes want 0", scan_errs());
        else pass_cnt++;
        end_frame();
    endtask

    task automatic test_back_to_back();
        bit to;
        fill_ram(0, 0);
        snap();
        start_frame(1, 1);
        next_slot();
        OKOUT = 1'b0;
        next_slot();
        run_copy(-1, -1, -1, to);
        check_cnt++;
        if (to || wq.size() - b_wq != N) $display("FAIL b2b_first: got %0d writes want %0d", wq.size() - b_wq, N);
        else pass_cnt++;
        end_frame();
        fill_ram(0, 0);
        snap();
        start_frame(0, 0);
        next_slot();
        check_cnt++;
        if (bus_req !== 1'b1) $display("FAIL b2b_kept_ok: got %b want 1", bus_req);
        else pass_cnt++;
        next_slot();
        run_copy(-1, -1, -1, to);
        check_cnt++;
        if (to || wq.size() - b_wq != N || scan_errs() != 0)
            $display("FAIL b2b_second: got %0d writes %0d bad want %0d 0", wq.size() - b_wq, scan_errs(), N);
        else pass_cnt++;
        end_frame();
    endtask

`ifdef JT1943_OBJDMA_PAUSE_EN
    task automatic test_pause();
        bit to;
        int seen = 0;
        pause = 1'b1;
        fill_ram(0, 0);
        snap();
        start_frame(1, 0);
        for (int i = 0; i < 20; i++) begin
            next_slot();
            if (bus_req) seen++;
        end
        check_cnt++;
        if (seen != 0) $display("FAIL pause_block: got %0d slots with bus_req want 0", seen);
        else pass_cnt++;
        end_frame();
        pause = 1'b0;
        start_frame(0, 0);
        next_slot();
        check_cnt++;
        if (bus_req !== 1'b1) $display("FAIL pause_resume: got %b want 1", bus_req);
        else pass_cnt++;
        next_slot();
        run_copy(-1, -1, -1, to);
        check_cnt++;
        if (to || wq.size() - b_wq != N || scan_errs() != 0)
            $display("FAIL pause_copy: got %0d writes %0d bad want %0d 0", wq.size() - b_wq, scan_errs(), N);
        else pass_cnt++;
        end_frame();
    endtask
`endif

    initial begin
        test_reset();
        test_full();
        test_no_okout();
        test_ack_drop();
        test_abort();
        test_reset_mid();
        test_back_to_back();
`ifdef JT1943_OBJDMA_PAUSE_EN
        test_pause();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
